// File: rtl/stepper_motor_emulator.sv
// Stepper shaft emulator: decodes coil drive into phase, position and faults.
// Optional revolution tracking (ANGLE/REV) is built when MOTOR_EMU_REV_EN is defined.
module stepper_motor_emulator #(
    parameter int POS_W         = 16,
    parameter int STEPS_PER_REV = 400,
    parameter int REV_W         = 8
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             A,
    input  logic                             B,
    input  logic                             C,
    input  logic                             D,
    input  logic                             INH1,
    input  logic                             INH2,
    input  logic                             ERR_CLR,
    output logic [2:0]                       PHASE,
    output logic [POS_W-1:0]                 POSITION,
    output logic                             DIR,
    output logic                             HALF,
    output logic                             STEP,
    output logic                             ERROR,
    output logic [$clog2(STEPS_PER_REV)-1:0] ANGLE,
    output logic [REV_W-1:0]                 REV
);

    localparam int ANG_W = $clog2(STEPS_PER_REV);

    logic [5:0]       pat;
    logic             pat_ok;
    logic [2:0]       new_ph;
    logic [2:0]       delta;
    logic signed [3:0] mv;
    logic             fault;

    logic [2:0]       phase_q, phase_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             half_q, half_d;
    logic             step_q, step_d;
    logic             err_q, err_d;

    // Map the six drive lines onto a half-step phase index
    always_comb begin
        pat    = {A, B, C, D, INH1, INH2};
        pat_ok = 1'b1;
        new_ph = 3'd0;
        case (pat)
            6'b010111: new_ph = 3'd0;
            6'b001101: new_ph = 3'd1;
            6'b100111: new_ph = 3'd2;
            6'b100010: new_ph = 3'd3;
            6'b101011: new_ph = 3'd4;
            6'b001001: new_ph = 3'd5;
            6'b011011: new_ph = 3'd6;
            6'b010010: new_ph = 3'd7;
            default:   pat_ok = 1'b0;
        endcase
    end

    // Classify the phase change and derive the next shaft state
    always_comb begin
        delta   = new_ph - phase_q;
        mv      = 4'sd0;
        fault   = 1'b0;
        phase_d = phase_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        half_d  = half_q;
        step_d  = 1'b0;
        if (!pat_ok) begin
            fault = 1'b1;
        end else begin
            case (delta)
                3'd0: mv = 4'sd0;
                3'd1: mv = 4'sd1;
                3'd7: mv = -4'sd1;
                3'd2: mv = 4'sd2;
                3'd6: mv = -4'sd2;
                default: begin
                    // Missed step: trust the new phase, keep position
                    fault   = 1'b1;
                    phase_d = new_ph;
                end
            endcase
        end
        if (mv != 4'sd0) begin
            phase_d = new_ph;
            pos_d   = pos_q + {{(POS_W-4){mv[3]}}, mv};
            dir_d   = ~mv[3];
            half_d  = (mv == 4'sd1) || (mv == -4'sd1);
            step_d  = 1'b1;
        end
        // A fresh fault outranks a clear in the same cycle
        err_d = fault | (err_q & ~ERR_CLR);
    end

    // Core shaft state registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            phase_q <= 3'd0;
            pos_q   <= '0;
            dir_q   <= 1'b1;
            half_q  <= 1'b1;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            half_q  <= half_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign PHASE    = phase_q;
    assign POSITION = pos_q;
    assign DIR      = dir_q;
    assign HALF     = half_q;
    assign STEP     = step_q;
    assign ERROR    = err_q;

`ifdef MOTOR_EMU_REV_EN
    logic [ANG_W-1:0]        angle_q, angle_d;
    logic [REV_W-1:0]        rev_q, rev_d;
    logic signed [ANG_W+1:0] ang_sum;

    // Fold the move into the angle, carrying whole revolutions into REV
    always_comb begin
        ang_sum = $signed({2'b00, angle_q}) + {{(ANG_W-2){mv[3]}}, mv};
        angle_d = angle_q;
        rev_d   = rev_q;
        if (mv != 4'sd0) begin
            if (ang_sum >= STEPS_PER_REV) begin
                angle_d = ANG_W'(ang_sum - STEPS_PER_REV);
                rev_d   = rev_q + REV_W'(1);
            end else if (ang_sum < 0) begin
                angle_d = ANG_W'(ang_sum + STEPS_PER_REV);
                rev_d   = rev_q - REV_W'(1);
            end else begin
                angle_d = ANG_W'(ang_sum);
            end
        end
    end

    // Revolution tracking registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            angle_q <= '0;
            rev_q   <= '0;
        end else begin
            angle_q <= angle_d;
            rev_q   <= rev_d;
        end
    end

    assign ANGLE = angle_q;
    assign REV   = rev_q;
`else
    assign ANGLE = '0;
    assign REV   = '0;
`endif

endmodule
